// File: rtl/mips_reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and the MIPS core.
// master: sequencer side, slave: core/register-file side.
interface mips_reset_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              soft_rst_req;
    logic              core_rst_n;
    logic              core_stall;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              run;
    logic              seq_done;

    modport master (
        input  soft_rst_req,
        output core_rst_n,
        output core_stall,
        output clr_we,
        output clr_addr,
        output run,
        output seq_done
    );

    modport slave (
        output soft_rst_req,
        input  core_rst_n,
        input  core_stall,
        input  clr_we,
        input  clr_addr,
        input  run,
        input  seq_done
    );
endinterface

// File: rtl/mips_reset_sequencer.sv
// Ordered core bring-up: HOLD -> CLEAR -> FLUSH -> RUN, restartable by soft reset.
// Register-file clear walk is compiled in only when MIPS_RSTSEQ_CLEAR_EN is defined.
module mips_reset_sequencer #(
    parameter int HOLD_CYCLES  = 4,
    parameter int NUM_REGS     = 32,
    parameter int ADDR_W       = 5,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    mips_reset_sequencer_if.master  bus
);

    localparam int MAXN01 = (HOLD_CYCLES > NUM_REGS) ? HOLD_CYCLES : NUM_REGS;
    localparam int MAXN   = (MAXN01 > FLUSH_CYCLES) ? MAXN01 : FLUSH_CYCLES;
    localparam int CNT_W  = $clog2(MAXN + 1);

    localparam logic [1:0] S_HOLD  = 2'd0;
`ifdef MIPS_RSTSEQ_CLEAR_EN
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(NUM_REGS - 1);
`endif
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_n_q;
    logic             stall_q;
    logic             run_q;
    logic             done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        unique case (state_q)
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
`ifdef MIPS_RSTSEQ_CLEAR_EN
                    state_d = S_CLEAR;
`else
                    state_d = S_FLUSH;
`endif
                    cnt_d   = '0;
                end
            end
`ifdef MIPS_RSTSEQ_CLEAR_EN
            S_CLEAR: begin
                if (cnt_q == CLEAR_LAST) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end
            end
`endif
            S_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q;
                // A soft request replays the whole bring-up from HOLD
                if (bus.soft_rst_req) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            rst_n_q <= 1'b0;
            stall_q <= 1'b1;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_n_q <= (state_d == S_FLUSH) || (state_d == S_RUN);
            stall_q <= (state_d != S_RUN);
            run_q   <= (state_d == S_RUN);
            done_q  <= (state_d == S_RUN) && (state_q != S_RUN);
        end
    end

`ifdef MIPS_RSTSEQ_CLEAR_EN
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
        end else begin
            we_q   <= (state_d == S_CLEAR);
            addr_q <= (state_d == S_CLEAR) ? ADDR_W'(cnt_d) : '0;
        end
    end

    assign bus.clr_we   = we_q;
    assign bus.clr_addr = addr_q;
`else
    assign bus.clr_we   = 1'b0;
    assign bus.clr_addr = '0;
`endif

    assign bus.core_rst_n = rst_n_q;
    assign bus.core_stall = stall_q;
    assign bus.run        = run_q;
    assign bus.seq_done   = done_q;

endmodule

// File: doc/mips_reset_sequencer.md
# mips_reset_sequencer

Receiving end of the processor's top-level reset: consumes the board/bench `reset` line and turns it into an ordered bring-up of the MIPS core. It holds the core in reset, walks the register file to zero, then releases the pipeline with a fetch stall before asserting run. It also serves in-flight soft-reset requests from the core. It sits inside `MIPS`, between the top-level `clk`/`reset` ports and the datapath/register file.

## Interface
- `HOLD_CYCLES`, 4: cycles the core stays in reset after `reset` deasserts (≥1).
- `NUM_REGS`, 32: register-file entries cleared (≤2^`ADDR_W`).
- `ADDR_W`, 5: register address width.
- `FLUSH_CYCLES`, 3: cycles the core runs stalled after reset release (≥1).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low reset; sampled on `clk` rising edge; 0 = reset.
- `soft_rst_req` in 1: single-cycle request from core to restart bring-up.
- `core_rst_n` out 1: active-low reset to datapath/control.
- `core_stall` out 1: freezes PC and pipeline registers.
- `clr_we` out 1: register-file write enable for the clear walk (write data forced to 0 externally).
- `clr_addr` out `ADDR_W`: register-file address for the clear walk.
- `run` out 1: core fully released.
- `seq_done` out 1: one-cycle pulse on entry to RUN.

## Operation
- States: HOLD, CLEAR, FLUSH, RUN. One internal counter, wide enough for max(`HOLD_CYCLES`, `NUM_REGS`, `FLUSH_CYCLES`).
- Any edge with `reset`=0: state←HOLD, counter←0. Outputs become `core_rst_n`=0, `core_stall`=1, `clr_we`=0, `clr_addr`=0, `run`=0, `seq_done`=0. These are the reset values.
- Each state lasts exactly N cycles. It is entered at edge Ek and left at edge Ek+N, where N = `HOLD_CYCLES`, `NUM_REGS`, or `FLUSH_CYCLES` respectively.
- HOLD: `core_rst_n`=0, `core_stall`=1, `clr_we`=0. Then goes to CLEAR.
- CLEAR: `core_rst_n`=0, `clr_we`=1. `clr_addr` = 0,1,…,`NUM_REGS`-1, one per cycle, including r0. Then goes to FLUSH.
- FLUSH: `core_rst_n`=1, `core_stall`=1, `clr_we`=0, `clr_addr`=0. Then goes to RUN.
- RUN: `core_rst_n`=1, `core_stall`=0, `run`=1. `seq_done`=1 for only the first cycle.
- `soft_rst_req` is sampled only in RUN. When high, it behaves exactly like `reset`=0 for one edge (state←HOLD, outputs at reset values). It is ignored in other states; there is no queuing.
- Simultaneous `reset`=0 and `soft_rst_req`=1: `reset` wins, with identical outcome.
- `reset` low mid-sequence aborts immediately at that edge. The walk restarts from address 0 on the next release.

## Timing
- All outputs are registered; no combinational input→output paths.
- E0 = last edge with `reset`=0. With defaults:
  - CLEAR entered at E4; `clr_addr`=31 after E35.
  - FLUSH entered at E36 (`core_rst_n` rises).
  - RUN entered at E39; `seq_done` high E39→E40.
- General latency from E0 to `run`: `HOLD_CYCLES`+`NUM_REGS`+`FLUSH_CYCLES` edges. The clear walk is excluded when disabled (see Configuration).
- Soft reset accepted at edge Ek: `run` low after Ek, high again after Ek+39 (defaults).

## Configuration
- `MIPS_RSTSEQ_CLEAR_EN` defined: CLEAR state and walk compiled in, as above.
- Not defined: CLEAR is removed, HOLD goes directly to FLUSH, and `clr_we`/`clr_addr` are tied to 0. Latency is `HOLD_CYCLES`+`FLUSH_CYCLES`, so `run` rises at E7 with defaults.

## Test plan
- `reset`=0 for 2 cycles, then 1 → all outputs at reset values while low; `core_rst_n` rises at E36, `run` at E39, `seq_done` high exactly one cycle.
- Clear walk → `clr_we`=1 for exactly 32 cycles, `clr_addr` 0..31 in order with no gaps or repeats; `clr_we`=0 when `core_rst_n`=1.
- `reset` pulsed low for one cycle when `clr_addr`=17 → outputs return to reset values after that edge; the walk restarts at 0; `run` at E0+39 from the new low edge.
- `soft_rst_req` pulse in RUN → `run`=0 and `core_rst_n`=0 next cycle, full sequence repeats; a pulse during FLUSH → no effect, `run` still rises on schedule.
- Same-edge `reset`=0 and `soft_rst_req`=1 → identical to reset alone.
- Build without `MIPS_RSTSEQ_CLEAR_EN` → `clr_we` never 1; `run` at E7.
